// File: rtl/rf_pkg.sv
// ============================================================================
// Module : rf_pkg
// Brief  : Shared defaults and select-range helper for the bypass register file
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_pkg;

    localparam int C_DATA_W_DEFAULT   = 16;
    localparam int C_NUM_REGS_DEFAULT = 8;

    function automatic logic sel_in_range(input int sel, input int num_regs);
        return sel < num_regs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_bypass_reg.sv
// ============================================================================
// Module : rf_bypass_reg
// Brief  : One register with write enable and scoreboard busy bit
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_bypass_reg #(
    parameter int DATA_W         = 16,
    parameter bit HARDWIRED_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              busy_set_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    generate
        if (HARDWIRED_ZERO) begin : g_zero
            logic w_unused;
            assign w_unused = ^{clk, rst, wr_en_i, wr_data_i, busy_set_i};
            assign data_o   = '0;
            assign busy_o   = 1'b0;
        end else begin : g_reg
            logic [DATA_W-1:0] data_q, data_d;
            logic              busy_q, busy_d;

            // A reservation in the same cycle as the retiring write wins.
            always_comb begin
                data_d = wr_en_i ? wr_data_i : data_q;
                busy_d = busy_set_i ? 1'b1 : (wr_en_i ? 1'b0 : busy_q);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                    busy_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    busy_q <= busy_d;
                end
            end

            assign data_o = data_q;
            assign busy_o = busy_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rf_bypass_param.sv
// ============================================================================
// Module : rf_bypass_param
// Brief  : Parameterised register file with write bypass and busy scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_bypass_param
    import rf_pkg::*;
#(
    parameter int DATA_W   = C_DATA_W_DEFAULT,
    parameter int NUM_REGS = C_NUM_REGS_DEFAULT,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  read1RegSel,
    input  logic [SEL_W-1:0]  read2RegSel,
    output logic [DATA_W-1:0] read1Data,
    output logic [DATA_W-1:0] read2Data,
    output logic              read1Busy,
    output logic              read2Busy,
    input  logic [SEL_W-1:0]  writeRegSel,
    input  logic [DATA_W-1:0] writeData,
    input  logic              writeEn,
    input  logic              busySetEn,
    input  logic [SEL_W-1:0]  busySetSel,
    output logic              err
);

    logic [DATA_W-1:0]            w_data [NUM_REGS];
    logic [NUM_REGS-1:0]          w_busy;
    logic [NUM_REGS-1:0]          w_wr_hit;
    logic [NUM_REGS-1:0]          w_set_hit;
    logic [1:0][SEL_W-1:0]        w_rd_sel;
    logic [1:0][DATA_W-1:0]       w_rd_data;
    logic [1:0]                   w_rd_busy;
    logic                         w_wr_legal;
    logic                         w_set_legal;
    logic                         err_q, err_d;

    assign w_wr_legal  = sel_in_range(32'(writeRegSel), NUM_REGS);
    assign w_set_legal = sel_in_range(32'(busySetSel), NUM_REGS);

    // Out-of-range selects never match any index, so they drop naturally.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
            assign w_wr_hit[i]  = ~rst & writeEn   & (writeRegSel == SEL_W'(i));
            assign w_set_hit[i] = ~rst & busySetEn & (busySetSel  == SEL_W'(i));

            rf_bypass_reg #(
                .DATA_W         (DATA_W),
                .HARDWIRED_ZERO (ZERO_R0 && (i == 0))
            ) u_reg (
                .clk        (clk),
                .rst        (rst),
                .wr_en_i    (w_wr_hit[i]),
                .wr_data_i  (writeData),
                .busy_set_i (w_set_hit[i]),
                .data_o     (w_data[i]),
                .busy_o     (w_busy[i])
            );
        end
    endgenerate

    assign w_rd_sel = {read2RegSel, read1RegSel};

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            logic              w_legal, w_fwd, w_set_same, w_busy_sel;
            logic [DATA_W-1:0] w_data_sel;

            always_comb begin
                w_data_sel = '0;
                w_busy_sel = 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_rd_sel[p] == SEL_W'(i)) begin
                        w_data_sel = w_data[i];
                        w_busy_sel = w_busy[i];
                    end
                end
            end

            assign w_legal    = sel_in_range(32'(w_rd_sel[p]), NUM_REGS);
            assign w_fwd      = BYPASS & writeEn & (writeRegSel == w_rd_sel[p]) & w_legal
                                & ~(ZERO_R0 & (w_rd_sel[p] == '0));
            assign w_set_same = busySetEn & (busySetSel == w_rd_sel[p]);

            // Reads show reset values for the whole time reset is held.
            assign w_rd_data[p] = rst ? '0 : (w_fwd ? writeData : w_data_sel);
            assign w_rd_busy[p] = ~rst & w_busy_sel & ~(w_fwd & ~w_set_same);
        end
    endgenerate

    assign read1Data = w_rd_data[0];
    assign read2Data = w_rd_data[1];
    assign read1Busy = w_rd_busy[0];
    assign read2Busy = w_rd_busy[1];

    assign err_d = ~rst & ((writeEn & ~w_wr_legal) | (busySetEn & ~w_set_legal));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_bypass_param.sv
// ============================================================================
// Module : tb_rf_bypass_param
// Brief  : Directed vectors, corner sequences and a random model comparison
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_bypass_param;

    logic        clk;
    logic        rst, we, bse;
    logic [2:0]  wsel, bsel, r1, r2;
    logic [15:0] wdata;

    logic [15:0] a_d1, a_d2, b_d1, b_d2;
    logic        a_b1, a_b2, a_err, b_b1, b_b2, b_err;

    int n_checks = 0;
    int n_errors = 0;

    rf_bypass_param u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (r1),
        .read2RegSel (r2),
        .read1Data   (a_d1),
        .read2Data   (a_d2),
        .read1Busy   (a_b1),
        .read2Busy   (a_b2),
        .writeRegSel (wsel),
        .writeData   (wdata),
        .writeEn     (we),
        .busySetEn   (bse),
        .busySetSel  (bsel),
        .err         (a_err)
    );

    rf_bypass_param #(
        .DATA_W   (16),
        .NUM_REGS (6),
        .BYPASS   (1'b0),
        .ZERO_R0  (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (r1),
        .read2RegSel (r2),
        .read1Data   (b_d1),
        .read2Data   (b_d2),
        .read1Busy   (b_b1),
        .read2Busy   (b_b2),
        .writeRegSel (wsel),
        .writeData   (wdata),
        .writeEn     (we),
        .busySetEn   (bse),
        .busySetSel  (bsel),
        .err         (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [2:0]  wsel;
        logic [15:0] wdata;
        logic        bse;
        logic [2:0]  bsel, r1, r2;
        logic [15:0] e_d1, e_d2;
        logic        e_b1, e_b2, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input int i_rst, i_we, i_wsel, i_wdata, i_bse, i_bsel,
                           i_r1, i_r2, i_d1, i_d2, i_b1, i_b2, i_err);
        vec_t v;
        v.rst = 1'(i_rst);   v.we = 1'(i_we);       v.wsel = 3'(i_wsel);
        v.wdata = 16'(i_wdata); v.bse = 1'(i_bse);  v.bsel = 3'(i_bsel);
        v.r1 = 3'(i_r1);     v.r2 = 3'(i_r2);
        v.e_d1 = 16'(i_d1);  v.e_d2 = 16'(i_d2);
        v.e_b1 = 1'(i_b1);   v.e_b2 = 1'(i_b2);     v.e_err = 1'(i_err);
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic i_rst, i_we, input logic [2:0] i_wsel,
                          input logic [15:0] i_wdata, input logic i_bse,
                          input logic [2:0] i_bsel, i_r1, i_r2);
        rst = i_rst; we = i_we; wsel = i_wsel; wdata = i_wdata;
        bse = i_bse; bsel = i_bsel; r1 = i_r1; r2 = i_r2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for both configurations.
    logic [7:0][15:0] ma_reg, mb_reg;
    logic [7:0]       ma_busy, mb_busy;
    logic             ma_err, mb_err;

    task automatic m_read(input int nregs, input bit byp, input bit zr,
                          input logic [7:0][15:0] regs, input logic [7:0] busy,
                          input logic [2:0] sel, output logic [15:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (rst || int'(sel) >= nregs || (zr && sel == 3'd0)) return;
        d = regs[sel];
        b = busy[sel];
        if (byp && we && wsel == sel) begin
            d = wdata;
            if (!(bse && bsel == sel)) b = 1'b0;
        end
    endtask

    task automatic m_update(input int nregs, input bit zr,
                            inout logic [7:0][15:0] regs, inout logic [7:0] busy,
                            inout logic e);
        if (rst) begin
            regs = '0;
            busy = '0;
            e    = 1'b0;
        end else begin
            e = (we && int'(wsel) >= nregs) || (bse && int'(bsel) >= nregs);
            if (we && int'(wsel) < nregs && !(zr && wsel == 3'd0)) begin
                regs[wsel] = wdata;
                busy[wsel] = 1'b0;
            end
            if (bse && int'(bsel) < nregs && !(zr && bsel == 3'd0))
                busy[bsel] = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] ed1, ed2;
        logic        eb1, eb2;

        set_in(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;

        //      rst we ws wdata    bse bs r1 r2  d1       d2       b1 b2 err
        add_vec(1,  1, 3, 'hAAAA,  1,  3, 3, 0,  'h0000,  'h0000,  0, 0, 0);
        add_vec(0,  0, 0, 0,       0,  0, 3, 0,  'h0000,  'h0000,  0, 0, 0);
        add_vec(0,  1, 3, 'hBEEF,  0,  0, 3, 4,  'hBEEF,  'h0000,  0, 0, 0);
        add_vec(0,  0, 0, 0,       0,  0, 3, 3,  'hBEEF,  'hBEEF,  0, 0, 0);
        add_vec(0,  0, 0, 0,       1,  5, 5, 5,  'h0000,  'h0000,  0, 0, 0);
        add_vec(0,  0, 0, 0,       0,  0, 5, 5,  'h0000,  'h0000,  1, 1, 0);
        add_vec(0,  1, 5, 'h1234,  0,  0, 3, 5,  'hBEEF,  'h1234,  0, 0, 0);
        add_vec(0,  1, 2, 'h5555,  1,  2, 2, 5,  'h5555,  'h1234,  0, 0, 0);
        add_vec(0,  0, 0, 0,       0,  0, 2, 2,  'h5555,  'h5555,  1, 1, 0);
        add_vec(0,  1, 2, 'h6666,  1,  2, 2, 0,  'h6666,  'h0000,  1, 0, 0);
        add_vec(0,  1, 7, 'h7777,  0,  0, 7, 2,  'h7777,  'h6666,  0, 1, 0);
        add_vec(0,  0, 0, 0,       0,  0, 7, 5,  'h7777,  'h1234,  0, 0, 0);
        add_vec(1,  0, 0, 0,       0,  0, 2, 7,  'h0000,  'h0000,  0, 0, 0);
        add_vec(0,  0, 0, 0,       0,  0, 2, 3,  'h0000,  'h0000,  0, 0, 0);
        add_vec(0,  1, 0, 'hFFFF,  0,  0, 0, 1,  'hFFFF,  'h0000,  0, 0, 0);

        foreach (tbl[k]) begin
            set_in(tbl[k].rst, tbl[k].we, tbl[k].wsel, tbl[k].wdata,
                   tbl[k].bse, tbl[k].bsel, tbl[k].r1, tbl[k].r2);
            @(negedge clk);
            chk($sformatf("vec%0d_d1", k),  a_d1,         tbl[k].e_d1);
            chk($sformatf("vec%0d_d2", k),  a_d2,         tbl[k].e_d2);
            chk($sformatf("vec%0d_b1", k),  16'(a_b1),    16'(tbl[k].e_b1));
            chk($sformatf("vec%0d_b2", k),  16'(a_b2),    16'(tbl[k].e_b2));
            chk($sformatf("vec%0d_err", k), 16'(a_err),   16'(tbl[k].e_err));
            next_cycle();
        end

        // No-bypass / hardwired-zero / 6-register configuration.
        set_in(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        next_cycle();
        set_in(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0);
        @(negedge clk);
        chk("b_nobypass_d1", b_d1, 16'h0000);
        chk("a_bypass_d1",   a_d1, 16'hBEEF);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd0);
        @(negedge clk);
        chk("b_late_d1", b_d1, 16'hBEEF);
        next_cycle();
        set_in(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        chk("b_r0_wrcycle", b_d1, 16'h0000);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        chk("b_r0_after", b_d1, 16'h0000);
        chk("b_err_idle", 16'(b_err), 16'h0);
        next_cycle();
        set_in(1'b0, 1'b1, 3'd7, 16'h1111, 1'b0, 3'd0, 3'd7, 3'd3);
        @(negedge clk);
        chk("b_illegal_rd", b_d1, 16'h0000);
        chk("b_err_pre",    16'(b_err), 16'h0);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd1, 3'd3);
        @(negedge clk);
        chk("b_err_wr7",  16'(b_err), 16'h1);
        chk("b_keep_r3",  b_d2, 16'hBEEF);
        chk("b_keep_r1",  b_d1, 16'h0000);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd0, 3'd0);
        @(negedge clk);
        chk("b_err_drop", 16'(b_err), 16'h0);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        @(negedge clk);
        chk("b_err_set6", 16'(b_err), 16'h1);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd0, 3'd4);
        @(negedge clk);
        chk("b_err_clear", 16'(b_err), 16'h0);
        chk("b_r0_busy",   16'(b_b1),  16'h0);
        next_cycle();
        set_in(1'b0, 1'b1, 3'd4, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd4);
        @(negedge clk);
        chk("b_busy_nobyp", 16'(b_b2), 16'h1);
        chk("b_data_nobyp", b_d2, 16'h0000);
        next_cycle();
        set_in(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd4);
        @(negedge clk);
        chk("b_busy_clr", 16'(b_b2), 16'h0);
        chk("b_data_r4",  b_d2, 16'h2222);
        next_cycle();

        // Random run against the reference model, both configurations.
        set_in(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        next_cycle();
        ma_reg = '0; mb_reg = '0; ma_busy = '0; mb_busy = '0; ma_err = 1'b0; mb_err = 1'b0;
        for (int c = 0; c < 500; c++) begin
            set_in(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 7)), 16'($urandom),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            @(negedge clk);
            m_read(8, 1'b1, 1'b0, ma_reg, ma_busy, r1, ed1, eb1);
            m_read(8, 1'b1, 1'b0, ma_reg, ma_busy, r2, ed2, eb2);
            chk("rnd_a_d1", a_d1, ed1);
            chk("rnd_a_d2", a_d2, ed2);
            chk("rnd_a_b1", 16'(a_b1), 16'(eb1));
            chk("rnd_a_b2", 16'(a_b2), 16'(eb2));
            chk("rnd_a_err", 16'(a_err), 16'(ma_err));
            m_read(6, 1'b0, 1'b1, mb_reg, mb_busy, r1, ed1, eb1);
            m_read(6, 1'b0, 1'b1, mb_reg, mb_busy, r2, ed2, eb2);
            chk("rnd_b_d1", b_d1, ed1);
            chk("rnd_b_d2", b_d2, ed2);
            chk("rnd_b_b1", 16'(b_b1), 16'(eb1));
            chk("rnd_b_b2", 16'(b_b2), 16'(eb2));
            chk("rnd_b_err", 16'(b_err), 16'(mb_err));
            m_update(8, 1'b0, ma_reg, ma_busy, ma_err);
            m_update(6, 1'b1, mb_reg, mb_busy, mb_err);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
